dct_1d_stage: RTL and testbench

//  Streaming 8-point 1-D DCT-II on 12-bit signed samples, one sample per enabled cycle.

---
 rtl/jpeg_pkg.sv | 28 ++
 rtl/dct_1d_stage_if.sv | 28 ++
 rtl/dct_1d_stage_coef_rom.sv | 14 +
 rtl/dct_1d_stage.sv | 122 ++++++++++++
 tb/tb_dct_1d_stage.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath definitions: sample/coefficient widths, types and the
// 8-point DCT-II cosine table used by both the row and column passes.
package jpeg_pkg;

  localparam int SAMPLE_W = 12;  // input sample width, signed
  localparam int OUT_W    = 12;  // output coefficient width, signed, saturated
  localparam int COEF_W   = 12;  // cosine table entry width, signed
  localparam int DCT_FRAC = 11;  // fractional bits of the cosine table
  localparam int DCT_N    = 8;   // transform length

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0]   coef_t;
  typedef logic signed [OUT_W-1:0]    dct_out_t;

  // DCT_COEF[k][n] = round(2^DCT_FRAC * c(k)/2 * cos((2n+1)*k*pi/16)),
  // c(0) = 1/sqrt(2), c(k>0) = 1.
  localparam coef_t DCT_COEF [DCT_N][DCT_N] = '{
    '{ 12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724},
    '{ 12'sd1004,  12'sd851,   12'sd569,   12'sd200,  -12'sd200,  -12'sd569,  -12'sd851,  -12'sd1004},
    '{ 12'sd946,   12'sd392,  -12'sd392,  -12'sd946,  -12'sd946,  -12'sd392,   12'sd392,   12'sd946},
    '{ 12'sd851,  -12'sd200,  -12'sd1004, -12'sd569,   12'sd569,   12'sd1004,  12'sd200,  -12'sd851},
    '{ 12'sd724,  -12'sd724,  -12'sd724,   12'sd724,   12'sd724,  -12'sd724,  -12'sd724,   12'sd724},
    '{ 12'sd569,  -12'sd1004,  12'sd200,   12'sd851,  -12'sd851,  -12'sd200,   12'sd1004, -12'sd569},
    '{ 12'sd392,  -12'sd946,   12'sd946,  -12'sd392,  -12'sd392,   12'sd946,  -12'sd946,   12'sd392},
    '{ 12'sd200,  -12'sd569,   12'sd851,  -12'sd1004,  12'sd1004, -12'sd851,   12'sd569,  -12'sd200}
  };

endpackage

// File: rtl/dct_1d_stage_if.sv
// Streaming sample/coefficient bus of one DCT pass. The master drives the
// enable and samples; the slave (the DCT stage) returns the coefficients.
interface dct_1d_stage_if;
  import jpeg_pkg::*;

  logic     ena_in;
  sample_t  S_in;
  dct_out_t S_out;
  logic     out_valid;
  logic     blk_start;

  modport master (
    output ena_in,
    output S_in,
    input  S_out,
    input  out_valid,
    input  blk_start
  );

  modport slave (
    input  ena_in,
    input  S_in,
    output S_out,
    output out_valid,
    output blk_start
  );

endinterface

// File: rtl/dct_1d_stage_coef_rom.sv
// Combinational cosine lookup: for the current sample index, hand every
// frequency lane k its coefficient C[k][n_idx].
module dct_coef_rom
  import jpeg_pkg::*;
(
  input  logic [2:0]                    n_idx,
  output logic [DCT_N-1:0][COEF_W-1:0]  coef
);

  for (genvar gi = 0; gi < DCT_N; gi++) begin : g_lane
    assign coef[gi] = DCT_COEF[gi][n_idx];
  end

endmodule

// File: rtl/dct_1d_stage.sv
// Streaming 8-point 1-D DCT-II. Eight MAC lanes accumulate one frequency each
// while x[0..7] arrive; the rounded/saturated results are loaded into an
// output bank on the x[7] edge and read out Y[0..7] while the next block
// accumulates, so blocks flow back-to-back with no bubbles.
module dct_1d_stage
  import jpeg_pkg::*;
#(
  parameter int IW   = SAMPLE_W,
  parameter int OW   = OUT_W,
  parameter int CW   = COEF_W,
  parameter int FRAC = DCT_FRAC
)(
  input  logic           clk,
  input  logic           rst,
  dct_1d_stage_if.slave  bus
);

  // 24-bit products plus 3 guard bits for the 8-term sum
  localparam int AW   = IW + CW + 3;
  localparam int SMAX = (2 ** (OW - 1)) - 1;
  localparam int SMIN = -(2 ** (OW - 1));

  logic [2:0]                n_idx_q, n_idx_d;
  logic [2:0]                out_idx_q, out_idx_d;
  logic                      loaded_q, loaded_d;
  logic signed [AW-1:0]      acc_q  [DCT_N];
  logic signed [AW-1:0]      acc_d  [DCT_N];
  logic signed [OW-1:0]      bank_q [DCT_N];
  logic signed [OW-1:0]      bank_d [DCT_N];
  logic signed [OW-1:0]      s_out_q, s_out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      blk_start_q, blk_start_d;

  logic [DCT_N-1:0][CW-1:0]  coef_w;
  logic signed [AW-1:0]      lane_sum [DCT_N];
  logic signed [OW-1:0]      lane_rnd [DCT_N];

  dct_coef_rom u_rom (
    .n_idx (n_idx_q),
    .coef  (coef_w)
  );

  // Per-lane multiply-accumulate with half-up rounding and saturation of the
  // running sum; only the value formed on the x[7] edge is ever loaded.
  for (genvar gi = 0; gi < DCT_N; gi++) begin : g_lane
    logic signed [IW+CW-1:0] prod;
    logic signed [AW-1:0]    base;
    logic        [AW:0]      biased;
    logic signed [AW-FRAC:0] shr;

    assign prod   = bus.S_in * $signed(coef_w[gi]);
    assign base   = (n_idx_q == 3'd0) ? '0 : acc_q[gi];
    assign lane_sum[gi] = base + {{(AW-IW-CW){prod[IW+CW-1]}}, prod};
    assign biased = {lane_sum[gi][AW-1], lane_sum[gi]} + (AW+1)'(2 ** (FRAC - 1));
    assign shr    = biased[AW:FRAC];
    assign lane_rnd[gi] = (shr > SMAX) ? OW'(SMAX) :
                          (shr < SMIN) ? OW'(SMIN) :
                          shr[OW-1:0];
  end

  // Next-state: advance input/output indices, accumulate, load bank on x[7]
  always_comb begin
    n_idx_d     = n_idx_q;
    out_idx_d   = out_idx_q;
    loaded_d    = loaded_q;
    acc_d       = acc_q;
    bank_d      = bank_q;
    s_out_d     = s_out_q;
    out_valid_d = out_valid_q;
    blk_start_d = blk_start_q;
    if (bus.ena_in) begin
      n_idx_d = n_idx_q + 3'd1;
      for (int k = 0; k < DCT_N; k++) begin
        acc_d[k] = lane_sum[k];
        if (n_idx_q == 3'd7) begin
          bank_d[k] = lane_rnd[k];
        end
      end
      if (n_idx_q == 3'd7) begin
        loaded_d = 1'b1;
      end
      // Readout uses the bank value present before this edge, so Y[7] of
      // one block leaves on the same edge the next block is loaded.
      if (loaded_q) begin
        s_out_d     = bank_q[out_idx_q];
        out_idx_d   = out_idx_q + 3'd1;
        out_valid_d = 1'b1;
        blk_start_d = (out_idx_q == 3'd0);
      end
    end
  end

  // State registers; reset wins over enable and discards any partial block
  always_ff @(posedge clk) begin
    if (rst) begin
      n_idx_q     <= '0;
      out_idx_q   <= '0;
      loaded_q    <= 1'b0;
      s_out_q     <= '0;
      out_valid_q <= 1'b0;
      blk_start_q <= 1'b0;
      for (int k = 0; k < DCT_N; k++) begin
        acc_q[k]  <= '0;
        bank_q[k] <= '0;
      end
    end else begin
      n_idx_q     <= n_idx_d;
      out_idx_q   <= out_idx_d;
      loaded_q    <= loaded_d;
      s_out_q     <= s_out_d;
      out_valid_q <= out_valid_d;
      blk_start_q <= blk_start_d;
      acc_q       <= acc_d;
      bank_q      <= bank_d;
    end
  end

  assign bus.S_out     = s_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.blk_start = blk_start_q;

endmodule

// File: tb/tb_dct_1d_stage.sv
// Bench for dct_1d_stage: directed DC / impulse / saturation blocks with
// hand-computed coefficients, random back-to-back streaming against a golden
// model whose cosine table is computed here from $cos, enable gating, and a
// reset in the middle of a block.
module tb_dct_1d_stage;

  logic clk;
  logic rst;
  dct_1d_stage_if bus();

  dct_1d_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  string cur_test = "init";

  // golden cosine table
  int tb_c [8][8];

  // behavioural model of the stage
  logic signed [11:0] m_x [8];
  int                 m_bank [8];
  logic [2:0]         m_n;
  logic [2:0]         m_oidx;
  bit                 m_loaded;
  int                 e_sout;
  bit                 e_valid;
  bit                 e_blk;
  bit                 hand_pending;
  int                 hand_vals [8];
  int                 blk_count;

  logic signed [11:0] blk_x [100][8];

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int golden(input int k, input logic signed [11:0] xs [8]);
    longint s;
    longint r;
    s = 0;
    for (int n = 0; n < 8; n++) s += longint'(xs[n]) * longint'(tb_c[k][n]);
    r = (s + 1024) >>> 11;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return int'(r);
  endfunction

  // One clock: drive at negedge, advance the model, check after posedge
  task automatic step(input bit r, input bit e, input logic signed [11:0] x);
    @(negedge clk);
    rst        = r;
    bus.ena_in = e;
    bus.S_in   = x;
    @(posedge clk);
    #1;
    if (r) begin
      m_n      = '0;
      m_oidx   = '0;
      m_loaded = 1'b0;
      e_sout   = 0;
      e_valid  = 1'b0;
      e_blk    = 1'b0;
    end else if (e) begin
      if (m_loaded) begin
        e_sout  = m_bank[m_oidx];
        e_blk   = (m_oidx == 3'd0);
        e_valid = 1'b1;
        m_oidx  = m_oidx + 3'd1;
      end
      m_x[m_n] = x;
      if (m_n == 3'd7) begin
        for (int k = 0; k < 8; k++)
          m_bank[k] = hand_pending ? hand_vals[k] : golden(k, m_x);
        hand_pending = 1'b0;
        m_loaded     = 1'b1;
      end
      m_n = m_n + 3'd1;
    end
    check_val({cur_test, ".s_out"},     bus.S_out,     e_sout);
    check_val({cur_test, ".out_valid"}, bus.out_valid, 32'(e_valid));
    check_val({cur_test, ".blk_start"}, bus.blk_start, 32'(e_blk));
  endtask

  // Feed one 8-sample block, optionally with random disabled cycles between
  task automatic feed_block(input logic signed [11:0] xs [8], input bit gated);
    for (int n = 0; n < 8; n++) begin
      if (gated) begin
        while ($urandom_range(0, 1) == 0)
          step(1'b0, 1'b0, 12'($urandom));
      end
      step(1'b0, 1'b1, xs[n]);
    end
    blk_count++;
    $display("[TB] %s block %0d fed, failures so far %0d", cur_test, blk_count, n_fail);
  endtask

  task automatic feed_hand(input logic signed [11:0] xs [8], input int hv [8]);
    hand_vals    = hv;
    hand_pending = 1'b1;
    feed_block(xs, 1'b0);
  endtask

  task automatic fill(output logic signed [11:0] xs [8], input logic signed [11:0] v);
    for (int n = 0; n < 8; n++) xs[n] = v;
  endtask

  initial begin
    logic signed [11:0] xs [8];
    int hv [8];
    real pi, ck, val;

    pi = 3.14159265358979;
    for (int k = 0; k < 8; k++) begin
      ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      for (int n = 0; n < 8; n++) begin
        val = 2048.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * pi / 16.0);
        tb_c[k][n] = $rtoi(val >= 0.0 ? val + 0.5 : val - 0.5);
      end
    end

    rst          = 1'b1;
    bus.ena_in   = 1'b0;
    bus.S_in     = '0;
    hand_pending = 1'b0;
    blk_count    = 0;
    m_n          = '0;
    m_oidx       = '0;
    m_loaded     = 1'b0;
    e_sout       = 0;
    e_valid      = 1'b0;
    e_blk        = 1'b0;

    // reset state
    cur_test = "reset";
    step(1'b1, 1'b0, 12'sd0);
    step(1'b1, 1'b1, 12'sd100);

    // directed blocks, back-to-back
    cur_test = "dc";
    fill(xs, 12'sd64);
    hv = '{181, 0, 0, 0, 0, 0, 0, 0};
    feed_hand(xs, hv);

    cur_test = "impulse";
    fill(xs, 12'sd0);
    xs[0] = 12'sd1000;
    hv = '{354, 490, 462, 416, 354, 278, 191, 98};
    feed_hand(xs, hv);

    cur_test = "sat_pos";
    fill(xs, 12'sd2047);
    hv = '{2047, 0, 0, 0, 0, 0, 0, 0};
    feed_hand(xs, hv);

    cur_test = "sat_neg";
    fill(xs, -12'sd2048);
    hv = '{-2048, 0, 0, 0, 0, 0, 0, 0};
    feed_hand(xs, hv);

    cur_test = "flush";
    fill(xs, 12'sd0);
    feed_block(xs, 1'b0);

    // random back-to-back streaming
    for (int b = 0; b < 100; b++)
      for (int n = 0; n < 8; n++)
        blk_x[b][n] = 12'($urandom);
    cur_test = "stream";
    step(1'b1, 1'b0, 12'sd0);
    for (int b = 0; b < 100; b++) begin
      for (int n = 0; n < 8; n++) xs[n] = blk_x[b][n];
      feed_block(xs, 1'b0);
    end
    fill(xs, 12'sd0);
    feed_block(xs, 1'b0);

    // same blocks with a gated enable
    cur_test = "gated";
    step(1'b1, 1'b0, 12'sd0);
    for (int b = 0; b < 100; b++) begin
      for (int n = 0; n < 8; n++) xs[n] = blk_x[b][n];
      feed_block(xs, 1'b1);
    end
    fill(xs, 12'sd0);
    feed_block(xs, 1'b1);

    // reset in the middle of a block, together with enable
    cur_test = "midrst";
    step(1'b1, 1'b0, 12'sd0);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 12'($urandom));
    step(1'b1, 1'b1, 12'sd777);
    fill(xs, 12'sd64);
    hv = '{181, 0, 0, 0, 0, 0, 0, 0};
    feed_hand(xs, hv);
    fill(xs, 12'sd0);
    feed_block(xs, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
